// File: rtl/slice_loader_pkg.sv
// +------------------------------------------------------------------+
// | slice_loader_pkg : shared constants and types for slice loading   |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
`default_nettype none

package slice_loader_pkg;
  localparam int SLICE_W = 25;
  localparam int DEPTH   = 64;
  localparam int IDX_W   = 6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef logic [SLICE_W-1:0] slice_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

`default_nettype wire

// File: rtl/slice_loader_buffer.sv
// +------------------------------------------------------------------+
// | slice_buffer : ENTRIES x WIDTH register array, one indexed write  |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
`default_nettype none

module slice_buffer #(
  parameter int WIDTH    = 25,
  parameter int ENTRIES  = 64,
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] idx_i,
  input  logic [WIDTH-1:0]    data_i,
  output logic [WIDTH-1:0]    data_o [0:ENTRIES-1]
);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic [WIDTH-1:0] entry_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_q <= '0;
      end else if (we_i && (idx_i == IDX_BITS'(g))) begin
        entry_q <= data_i;
      end
    end

    assign data_o[g] = entry_q;
  end

endmodule

`default_nettype wire

// File: rtl/slice_loader.sv
// +------------------------------------------------------------------+
// | slice_loader : fills a 64-slice buffer, fires the datapath, waits |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
`default_nettype none

module slice_loader
  import slice_loader_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  input  slice_t in_slice,
  output logic   in_ready,
  output slice_t out [0:DEPTH-1],
  output logic   start_instances,
  input  logic   all_ready,
  output logic   done,
  output logic   busy
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             armed_q;
  logic             in_ready_q;
  logic             start_q;
  logic             done_q;
  logic             busy_q;
  logic             wr_en;

  // in_ready_q is high exactly in LOAD, so this is the accept condition
  assign wr_en = in_valid & in_ready_q & ~flush;

  slice_buffer #(
    .WIDTH    (SLICE_W),
    .ENTRIES  (DEPTH),
    .IDX_BITS (IDX_W)
  ) u_buffer (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en),
    .idx_i  (idx_q),
    .data_i (in_slice),
    .data_o (out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      armed_q    <= 1'b0;
      in_ready_q <= 1'b1;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (flush) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      armed_q    <= 1'b0;
      in_ready_q <= 1'b1;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q    <= FIRE;
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end
        FIRE: begin
          state_q <= WAIT;
          start_q <= 1'b0;
          armed_q <= 1'b0;
        end
        WAIT: begin
          // first WAIT cycle only arms: instances may still show stale ready
          if (armed_q && all_ready) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            armed_q <= 1'b1;
          end
        end
        DONE: begin
          state_q    <= LOAD;
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= LOAD;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign busy            = busy_q;
  assign start_instances = start_q & ~flush;
  assign done            = done_q & ~flush;

endmodule

`default_nettype wire

// File: tb/tb_slice_loader.sv
// +------------------------------------------------------------------+
// | tb_slice_loader : directed bench for slice_loader                 |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
`default_nettype none

module tb_slice_loader;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [24:0] in_slice;
  logic        in_ready;
  logic [24:0] out_w [0:63];
  logic        start_instances;
  logic        all_ready;
  logic        done;
  logic        busy;

  int vectors;
  int miscompares;

  slice_loader dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_slice        (in_slice),
    .in_ready        (in_ready),
    .out             (out_w),
    .start_instances (start_instances),
    .all_ready       (all_ready),
    .done            (done),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Streams 64 slices base+i back-to-back; returns in the FIRE cycle.
  task automatic load_block(input int base);
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_slice = 25'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_slice = '0; all_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (out_w[i] !== 25'd0) begin
        miscompares++;
        $display("FAIL reset_out[%0d]: got %0d expected 0", i, out_w[i]);
      end
    end
    vectors++;
    if ({in_ready, start_instances, done, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy/start/done/busy=%b expected 1000",
               {in_ready, start_instances, done, busy});
    end
  endtask

  task automatic test_full_load;
    bit seen;
    all_ready = 1'b0;
    load_block(1);
    vectors++;
    if ({start_instances, in_ready, busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL full_fire: got start/rdy/busy=%b expected 101",
               {start_instances, in_ready, busy});
    end
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (out_w[i] !== 25'(i + 1)) begin
        miscompares++;
        $display("FAIL full_out[%0d]: got %0d expected %0d", i, out_w[i], i + 1);
      end
    end
    step();
    vectors++;
    if (start_instances !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL full_start_width: got start=%b busy=%b expected start=0 busy=1",
               start_instances, busy);
    end
    all_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL full_done: got no done within 10 cycles expected done");
    end
    all_ready = 1'b0;
    step();
  endtask

  task automatic test_gapped_stale;
    int done_at;
    all_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_slice = 25'(100 + i);
      step();
      if (i == 63) break;
      in_valid = 1'b0;
      in_slice = 25'h1ABCDE;
      step();
      if (i == 9) begin
        vectors++;
        if (out_w[9] !== 25'd109 || out_w[10] !== 25'd11) begin
          miscompares++;
          $display("FAIL gapped_idx: got out9=%0d out10=%0d expected 109 11",
                   out_w[9], out_w[10]);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (start_instances !== 1'b1 || out_w[63] !== 25'd163) begin
      miscompares++;
      $display("FAIL gapped_fire: got start=%b out63=%0d expected 1 163",
               start_instances, out_w[63]);
    end
    done_at = -1;
    for (int n = 1; n <= 8 && done_at < 0; n++) begin
      step();
      if (done === 1'b1) done_at = n;
    end
    vectors++;
    if (done_at !== 3) begin
      miscompares++;
      $display("FAIL gapped_done_latency: got %0d expected 3 cycles after FIRE", done_at);
    end
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL gapped_done_ctrl: got busy=%b rdy=%b expected 0 0", busy, in_ready);
    end
    all_ready = 1'b0;
    step();
  endtask

  task automatic test_wait_hold;
    int bad;
    all_ready = 1'b0;
    load_block(200);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (busy !== 1'b1 || done !== 1'b0 || out_w[5] !== 25'd205 || out_w[63] !== 25'd263)
        bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL wait_hold: got %0d bad cycles expected 0 (busy=%b out5=%0d)",
               bad, busy, out_w[5]);
    end
    all_ready = 1'b1;
    step();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_release: got done=%b busy=%b expected 1 0", done, busy);
    end
    all_ready = 1'b0;
    step();
    vectors++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_reopen: got rdy=%b done=%b expected 1 0", in_ready, done);
    end
  endtask

  task automatic test_flush;
    int dones;
    bit seen;
    all_ready = 1'b0;
    load_block(300);
    repeat (3) step();
    flush = 1'b1;
    #1;
    vectors++;
    if (done !== 1'b0 || start_instances !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_force: got done=%b start=%b expected 0 0", done, start_instances);
    end
    step();
    flush = 1'b0;
    all_ready = 1'b1;
    dones = 0;
    for (int n = 0; n < 4; n++) begin
      if (done === 1'b1) dones++;
      step();
    end
    vectors++;
    if (dones !== 0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_wait: got dones=%0d rdy=%b busy=%b expected 0 1 0",
               dones, in_ready, busy);
    end
    vectors++;
    if (out_w[0] !== 25'd300) begin
      miscompares++;
      $display("FAIL flush_keep: got out0=%0d expected 300", out_w[0]);
    end
    all_ready = 1'b0;
    load_block(400);
    vectors++;
    if (start_instances !== 1'b1 || out_w[0] !== 25'd400 || out_w[63] !== 25'd463) begin
      miscompares++;
      $display("FAIL flush_reload: got start=%b out0=%0d out63=%0d expected 1 400 463",
               start_instances, out_w[0], out_w[63]);
    end
    // Flush racing the last-slice handshake: flush must win.
    all_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    all_ready = 1'b0;
    step();
    for (int i = 0; i < 63; i++) begin
      in_valid = 1'b1;
      in_slice = 25'(500 + i);
      step();
    end
    in_slice = 25'd999;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (start_instances !== 1'b0 || in_ready !== 1'b1 || out_w[63] !== 25'd463) begin
      miscompares++;
      $display("FAIL flush_last: got start=%b rdy=%b out63=%0d expected 0 1 463",
               start_instances, in_ready, out_w[63]);
    end
    load_block(600);
    vectors++;
    if (start_instances !== 1'b1 || out_w[0] !== 25'd600) begin
      miscompares++;
      $display("FAIL flush_last_reload: got start=%b out0=%0d expected 1 600",
               start_instances, out_w[0]);
    end
    all_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL flush_drain: got no done within 10 cycles expected done");
    end
    all_ready = 1'b0;
    step();
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_slice = 25'(700 + i);
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if (out_w[29] !== 25'd729) begin
      miscompares++;
      $display("FAIL async_pre: got out29=%0d expected 729", out_w[29]);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (out_w[0] !== 25'd0 || out_w[29] !== 25'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_clear: got out0=%0d out29=%0d rdy=%b busy=%b expected 0 0 1 0",
               out_w[0], out_w[29], in_ready, busy);
    end
    #1;
    rst = 1'b1;
    step();
    in_valid = 1'b1;
    in_slice = 25'd777;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_w[0] !== 25'd777 || out_w[1] !== 25'd0) begin
      miscompares++;
      $display("FAIL async_restart: got out0=%0d out1=%0d expected 777 0",
               out_w[0], out_w[1]);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_full_load();
    test_gapped_stale();
    test_wait_hold();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
